// File: rtl/seq_pkg.sv
// Shared types and sizing helpers for the layer sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_NEXT,
    S_FINISH,
    S_FAULT
  } seq_state_e;

  localparam int unsigned DEF_LAYERS = 3;
  localparam int unsigned DEF_RAMS   = 7;
  localparam int unsigned DEF_DEPTH  = 256;
  localparam int unsigned DEF_WIDTH  = 16;

  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/seq_bus_mux.sv
// Selects one layer's RAM address/write-enable slice; drives zero when not enabled.
module seq_bus_mux #(
  parameter int unsigned NUM_LAYERS = 3,
  parameter int unsigned AW         = 8,
  parameter int unsigned NUM_RAMS   = 7,
  parameter int unsigned IW         = 2
) (
  input  logic                         en,
  input  logic [IW-1:0]                sel,
  input  logic [NUM_LAYERS*AW-1:0]     layer_addr_rd,
  input  logic [NUM_LAYERS*AW-1:0]     layer_addr_wr,
  input  logic [NUM_LAYERS*NUM_RAMS-1:0] layer_wren,
  output logic [AW-1:0]                ram_addr_rd,
  output logic [AW-1:0]                ram_addr_wr,
  output logic [NUM_RAMS-1:0]          ram_wren
);

  always_comb begin
    ram_addr_rd = '0;
    ram_addr_wr = '0;
    ram_wren    = '0;
    if (en) begin
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
        if (IW'(i) == sel) begin
          ram_addr_rd = layer_addr_rd[i*AW +: AW];
          ram_addr_wr = layer_addr_wr[i*AW +: AW];
          ram_wren    = layer_wren[i*NUM_RAMS +: NUM_RAMS];
        end
      end
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// Runs each layer engine in turn via start/done handshakes, grants the shared
// RAM bus to the active layer, ping-pongs banks and traps hung layers.
module layer_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned NUM_LAYERS     = DEF_LAYERS,
  parameter int unsigned NUM_RAMS       = DEF_RAMS,
  parameter int unsigned RAM_DEPTH      = DEF_DEPTH,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  localparam int unsigned AW  = addr_w(RAM_DEPTH),
  localparam int unsigned LW  = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1,
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [LW-1:0]                  active_layer,
  output logic                           buf_sel,
  output logic [NUM_LAYERS-1:0]          layer_start,
  input  logic [NUM_LAYERS-1:0]          layer_done,
  input  logic [NUM_LAYERS*AW-1:0]       layer_addr_rd,
  input  logic [NUM_LAYERS*AW-1:0]       layer_addr_wr,
  input  logic [NUM_LAYERS*NUM_RAMS-1:0] layer_wren,
  output logic [AW-1:0]                  ram_addr_rd,
  output logic [AW-1:0]                  ram_addr_wr,
  output logic [NUM_RAMS-1:0]            ram_wren
);

  localparam logic [LW-1:0]  LAST_IDX = LW'(NUM_LAYERS - 1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT_CYCLES - 1);

  seq_state_e     state, state_nx;
  logic [LW-1:0]  idx;
  logic [WDW-1:0] watchdog;
  logic           grant;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      buf_sel  <= 1'b0;
      watchdog <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          idx     <= '0;
          buf_sel <= 1'b0;
        end
        S_LAUNCH: watchdog <= '0;
        S_RUN:    watchdog <= watchdog + WDW'(1);
        S_NEXT: begin
          idx     <= idx + LW'(1);
          buf_sel <= ~buf_sel;
        end
        default: ;
      endcase
    end
  end

  // Completion is checked before the watchdog so a done on the limit cycle advances.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_LAUNCH;
      S_LAUNCH: state_nx = S_RUN;
      S_RUN: begin
        if (layer_done[idx])         state_nx = (idx == LAST_IDX) ? S_FINISH : S_NEXT;
        else if (watchdog == WD_LIMIT) state_nx = S_FAULT;
      end
      S_NEXT:   state_nx = S_LAUNCH;
      S_FINISH: state_nx = S_IDLE;
      S_FAULT:  state_nx = S_FAULT;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != S_IDLE) && (state != S_FAULT);
    done        = (state == S_FINISH);
    error       = (state == S_FAULT);
    grant       = (state == S_LAUNCH) || (state == S_RUN);
    layer_start = '0;
    if (state == S_LAUNCH) layer_start[idx] = 1'b1;
  end

  assign active_layer = idx;

  seq_bus_mux #(
    .NUM_LAYERS (NUM_LAYERS),
    .AW         (AW),
    .NUM_RAMS   (NUM_RAMS),
    .IW         (LW)
  ) u_bus_mux (
    .en            (grant),
    .sel           (idx),
    .layer_addr_rd (layer_addr_rd),
    .layer_addr_wr (layer_addr_wr),
    .layer_wren    (layer_wren),
    .ram_addr_rd   (ram_addr_rd),
    .ram_addr_wr   (ram_addr_wr),
    .ram_wren      (ram_wren)
  );

endmodule
